addsub_rr_scheduler: RTL

//   Shares a single 4-bit add/subtract datapath between N_REQ requesters.

---
 rtl/addsub_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/addsub_rr_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub round-robin scheduler.
// State encoding, operation modes and the id-width helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Index width; a single requester still needs a 1-bit id.
  function automatic int clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set req at or after ptr, wrapping upward.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt
);

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_sel;

  // Requests at or above ptr win; otherwise fall back to the wrap-around set.
  assign w_mask = ~((N_REQ'(1) << ptr) - N_REQ'(1));
  assign w_hi   = req & w_mask;
  assign w_sel  = (|w_hi) ? w_hi : req;
  assign gnt    = en ? (w_sel & (~w_sel + N_REQ'(1))) : '0;

endmodule

// File: rtl/addsub_rr_scheduler.sv
// One shared add/sub unit, round-robin among N_REQ requesters.
// One op in flight; registered result with valid/ready backpressure.
module addsub_rr_scheduler
  import addsub_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  input  logic [N_REQ-1:0]       mode_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_cb
);

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mode;
  logic [N_REQ-1:0] w_gnt;
  logic [IDW-1:0]   w_win_id;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_mode;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH:0]   w_sum;
  logic             w_hs;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .PW   (IDW)
  ) u_arb (
    .req(req),
    .ptr(r_ptr),
    .en (r_state == IDLE),
    .gnt(w_gnt)
  );

  assign gnt  = w_gnt;
  assign busy = (r_state != IDLE);
  assign w_hs = rsp_valid && rsp_ready;

  always_comb begin
    w_win_id = '0;
    w_a      = '0;
    w_b      = '0;
    w_mode   = MODE_ADD;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_id = IDW'(i);
        w_a      = a_in[i*WIDTH +: WIDTH];
        w_b      = b_in[i*WIDTH +: WIDTH];
        w_mode   = mode_in[i];
      end
    end
  end

  // Subtract as A + ~B + 1 so the top bit reads as "no borrow".
  assign w_sum = {1'b0, r_a}
               + {1'b0, (r_mode == MODE_SUB) ? ~r_b : r_b}
               + {{WIDTH{1'b0}}, r_mode};

  assign w_ptr_nxt = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (|req) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_mode     <= MODE_ADD;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_cb     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_id   <= w_win_id;
            r_a    <= w_a;
            r_b    <= w_b;
            r_mode <= w_mode;
          end
        end
        EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= r_id;
          rsp_result <= w_sum[WIDTH-1:0];
          rsp_cb     <= w_sum[WIDTH];
        end
        RESP: begin
          if (w_hs) begin
            rsp_valid <= 1'b0;
            r_ptr     <= w_ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
